// File: rtl/multi_range_finder.sv
// -----------------------------------------------------------------------------
// multi_range_finder
//   Tracks min, max, range and a saturating sample count for CHANNELS
//   independent, tagged sample streams that share one input bus. Each channel
//   runs its own IDLE/RUN/ERROR state machine, driven by a go/finish/clear
//   command bus. A registered result record pulses one cycle after a finish.
//
//   Optional build macro: RANGE_FINDER_SIGNED_EN
//     defined   -> samples are two's complement, compares are signed
//     undefined -> samples are unsigned (default)
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   data_in     in   sample value
//   data_valid  in   sample present this cycle
//   data_chan   in   channel tag of the sample
//   cmd         in   00 none, 01 go, 10 finish, 11 clear
//   cmd_chan    in   channel addressed by cmd
//   res_valid   out  one-cycle pulse, result record valid
//   res_chan    out  channel of the result
//   res_min     out  minimum of the run
//   res_max     out  maximum of the run
//   res_range   out  res_max - res_min (unsigned WIDTH bits)
//   res_count   out  samples in the run (saturated)
//   busy        out  bit c set while channel c is in RUN
//   error       out  bit c set while channel c is in ERROR
// -----------------------------------------------------------------------------
module multi_range_finder #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16,
  localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_valid,
  input  logic [CHW-1:0]       data_chan,
  input  logic [1:0]           cmd,
  input  logic [CHW-1:0]       cmd_chan,
  output logic                 res_valid,
  output logic [CHW-1:0]       res_chan,
  output logic [WIDTH-1:0]     res_min,
  output logic [WIDTH-1:0]     res_max,
  output logic [WIDTH-1:0]     res_range,
  output logic [CNT_WIDTH-1:0] res_count,
  output logic [CHANNELS-1:0]  busy,
  output logic [CHANNELS-1:0]  error
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_ERROR = 2'd2} state_e;

  localparam logic [1:0] CMD_GO     = 2'b01;
  localparam logic [1:0] CMD_FINISH = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]     VAL_ZERO = {WIDTH{1'b0}};

  // Empty-run seeds: the first real sample must win both compares.
`ifdef RANGE_FINDER_SIGNED_EN
  localparam logic [WIDTH-1:0] EMPTY_MIN = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] EMPTY_MAX = {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam logic [WIDTH-1:0] EMPTY_MIN = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] EMPTY_MAX = {WIDTH{1'b0}};
`endif

  function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef RANGE_FINDER_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Out-of-range channel tags (non power-of-two CHANNELS) are ignored.
  function automatic logic chan_ok(input logic [CHW-1:0] ch);
    return 32'(ch) < CHANNELS;
  endfunction

  state_e               state_q [CHANNELS];
  state_e               state_d [CHANNELS];
  logic [WIDTH-1:0]     min_q   [CHANNELS];
  logic [WIDTH-1:0]     min_d   [CHANNELS];
  logic [WIDTH-1:0]     max_q   [CHANNELS];
  logic [WIDTH-1:0]     max_d   [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_q   [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d   [CHANNELS];

  logic                 res_valid_q, res_valid_d;
  logic [CHW-1:0]       res_chan_q,  res_chan_d;
  logic [WIDTH-1:0]     res_min_q,   res_min_d;
  logic [WIDTH-1:0]     res_max_q,   res_max_d;
  logic [WIDTH-1:0]     res_range_q, res_range_d;
  logic [CNT_WIDTH-1:0] res_count_q, res_count_d;
  logic [CHANNELS-1:0]  busy_q,      busy_d;
  logic [CHANNELS-1:0]  error_q,     error_d;

  // Per-channel next state, statistics update and result capture.
  always_comb begin
    logic                 smp;
    logic                 hit;
    logic [WIDTH-1:0]     n_min;
    logic [WIDTH-1:0]     n_max;
    logic [CNT_WIDTH-1:0] n_cnt;

    state_d     = state_q;
    min_d       = min_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    res_valid_d = 1'b0;
    res_chan_d  = res_chan_q;
    res_min_d   = res_min_q;
    res_max_d   = res_max_q;
    res_range_d = res_range_q;
    res_count_d = res_count_q;
    busy_d      = {CHANNELS{1'b0}};
    error_d     = {CHANNELS{1'b0}};
    smp         = 1'b0;
    hit         = 1'b0;
    n_min       = VAL_ZERO;
    n_max       = VAL_ZERO;
    n_cnt       = CNT_ZERO;

    for (int c = 0; c < CHANNELS; c++) begin
      smp = data_valid && chan_ok(data_chan) && (data_chan == CHW'(c));
      hit = chan_ok(cmd_chan) && (cmd_chan == CHW'(c));

      // Statistics including this cycle's sample; min and max are independent
      // so a single sample can move both.
      n_min = (smp && less_than(data_in, min_q[c])) ? data_in : min_q[c];
      n_max = (smp && less_than(max_q[c], data_in)) ? data_in : max_q[c];
      n_cnt = (smp && (cnt_q[c] != CNT_MAX)) ? (cnt_q[c] + CNT_ONE) : cnt_q[c];

      case (state_q[c])
        S_IDLE: begin
          if (hit && (cmd == CMD_GO)) begin
            state_d[c] = S_RUN;
            if (smp) begin
              min_d[c] = data_in;
              max_d[c] = data_in;
              cnt_d[c] = CNT_ONE;
            end else begin
              min_d[c] = EMPTY_MIN;
              max_d[c] = EMPTY_MAX;
              cnt_d[c] = CNT_ZERO;
            end
          end else if (hit && (cmd == CMD_FINISH)) begin
            state_d[c] = S_ERROR;
          end else begin
            state_d[c] = S_IDLE;
          end
        end
        S_RUN: begin
          if (hit && (cmd == CMD_GO)) begin
            state_d[c] = S_ERROR;
          end else if (hit && (cmd == CMD_FINISH)) begin
            state_d[c]  = S_IDLE;
            res_valid_d = 1'b1;
            res_chan_d  = CHW'(c);
            // An empty run reports all zeros rather than the seed values.
            if (n_cnt == CNT_ZERO) begin
              res_min_d   = VAL_ZERO;
              res_max_d   = VAL_ZERO;
              res_range_d = VAL_ZERO;
              res_count_d = CNT_ZERO;
            end else begin
              res_min_d   = n_min;
              res_max_d   = n_max;
              res_range_d = n_max - n_min;
              res_count_d = n_cnt;
            end
          end else if (hit && (cmd == CMD_CLEAR)) begin
            state_d[c] = S_IDLE;
          end else begin
            state_d[c] = S_RUN;
            min_d[c]   = n_min;
            max_d[c]   = n_max;
            cnt_d[c]   = n_cnt;
          end
        end
        S_ERROR: begin
          if (hit && (cmd == CMD_CLEAR)) begin
            state_d[c] = S_IDLE;
          end else begin
            state_d[c] = S_ERROR;
          end
        end
        default: begin
          state_d[c] = S_IDLE;
        end
      endcase

      busy_d[c]  = (state_d[c] == S_RUN);
      error_d[c] = (state_d[c] == S_ERROR);
    end
  end

  // State, statistics and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= S_IDLE;
        min_q[c]   <= VAL_ZERO;
        max_q[c]   <= VAL_ZERO;
        cnt_q[c]   <= CNT_ZERO;
      end
      res_valid_q <= 1'b0;
      res_chan_q  <= {CHW{1'b0}};
      res_min_q   <= VAL_ZERO;
      res_max_q   <= VAL_ZERO;
      res_range_q <= VAL_ZERO;
      res_count_q <= CNT_ZERO;
      busy_q      <= {CHANNELS{1'b0}};
      error_q     <= {CHANNELS{1'b0}};
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        min_q[c]   <= min_d[c];
        max_q[c]   <= max_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      res_valid_q <= res_valid_d;
      res_chan_q  <= res_chan_d;
      res_min_q   <= res_min_d;
      res_max_q   <= res_max_d;
      res_range_q <= res_range_d;
      res_count_q <= res_count_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_chan  = res_chan_q;
  assign res_min   = res_min_q;
  assign res_max   = res_max_q;
  assign res_range = res_range_q;
  assign res_count = res_count_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule
